// File: rtl/vga_timing.sv
// 800x600@60 Hz VGA timing generator: free-running pixel/line counters with
// registered sync, blanking and end-of-frame flags, all aligned to the counts.
module vga_timing #(
    parameter int H_VISIBLE = 800,
    parameter int H_FP      = 40,
    parameter int H_SYNC    = 128,
    parameter int H_BP      = 88,
    parameter int V_VISIBLE = 600,
    parameter int V_FP      = 1,
    parameter int V_SYNC    = 4,
    parameter int V_BP      = 23
) (
    input  logic        clk40,
    input  logic        rst,
    output logic [10:0] hcount,
    output logic [10:0] vcount,
    output logic        hsync,
    output logic        vsync,
    output logic        hblnk,
    output logic        vblnk,
    output logic        frame_end
);

    localparam int H_TOTAL_I = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL_I = V_VISIBLE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL_I > 2048 || V_TOTAL_I > 2048) begin : gBadTotals
        $error("vga_timing: H_TOTAL and V_TOTAL must not exceed 2048");
    end

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL_I - 1);
    localparam logic [10:0] V_LAST       = 11'(V_TOTAL_I - 1);
    localparam logic [10:0] H_VIS        = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS        = 11'(V_VISIBLE);
    localparam logic [10:0] H_SYNC_FIRST = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] H_SYNC_LAST  = 11'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [10:0] V_SYNC_FIRST = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] V_SYNC_LAST  = 11'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [10:0] hcount_q, hcount_d;
    logic [10:0] vcount_q, vcount_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        hblnk_q, hblnk_d;
    logic        vblnk_q, vblnk_d;
    logic        frame_end_q, frame_end_d;

    // Out-of-range counts (only reachable by forcing) fall back to 0 next cycle.
    always_comb begin
        hcount_d = hcount_q + 11'd1;
        vcount_d = vcount_q;
        if (hcount_q >= H_LAST) begin
            hcount_d = '0;
            vcount_d = (vcount_q >= V_LAST) ? '0 : vcount_q + 11'd1;
        end else if (vcount_q > V_LAST) begin
            vcount_d = '0;
        end
    end

    // Flags decode the next-state counts so the registered outputs line up
    // with the registered counts and never glitch.
    always_comb begin
        hblnk_d     = (hcount_d >= H_VIS);
        vblnk_d     = (vcount_d >= V_VIS);
        hsync_d     = (hcount_d >= H_SYNC_FIRST) && (hcount_d <= H_SYNC_LAST);
        vsync_d     = (vcount_d >= V_SYNC_FIRST) && (vcount_d <= V_SYNC_LAST);
        frame_end_d = (hcount_d == H_LAST) && (vcount_d == V_LAST);
    end

    always_ff @(posedge clk40 or negedge rst) begin
        if (!rst) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            hcount_q    <= hcount_d;
            vcount_q    <= vcount_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            hblnk_q     <= hblnk_d;
            vblnk_q     <= vblnk_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign hcount    = hcount_q;
    assign vcount    = vcount_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign hblnk     = hblnk_q;
    assign vblnk     = vblnk_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_timing.sv
// Directed bench for vga_timing: full-size timing on one instance, frame-level
// behaviour on a shrunken instance so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_vga_timing;

    localparam int AHT = 1056;
    localparam int AVT = 628;
    localparam int BHT = 25;
    localparam int BVT = 15;

    logic clk40 = 1'b0;
    always #12.5 clk40 = ~clk40;

    logic        rstA, rstB;
    logic [10:0] hcountA, vcountA, hcountB, vcountB;
    logic        hsyncA, vsyncA, hblnkA, vblnkA, frame_endA;
    logic        hsyncB, vsyncB, hblnkB, vblnkB, frame_endB;

    vga_timing dutA (
        .clk40(clk40), .rst(rstA),
        .hcount(hcountA), .vcount(vcountA),
        .hsync(hsyncA), .vsync(vsyncA),
        .hblnk(hblnkA), .vblnk(vblnkA),
        .frame_end(frame_endA)
    );

    vga_timing #(
        .H_VISIBLE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_VISIBLE(10), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) dutB (
        .clk40(clk40), .rst(rstB),
        .hcount(hcountB), .vcount(vcountB),
        .hsync(hsyncB), .vsync(vsyncB),
        .hblnk(hblnkB), .vblnk(vblnkB),
        .frame_end(frame_endB)
    );

    int checkCount = 0;
    int failCount  = 0;
    int mH, mV;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Packed as {hsync, vsync, hblnk, vblnk, frame_end}.
    function automatic logic [4:0] expectFlags(int h, int v, int hVis, int hFp, int hSync,
                                               int vVis, int vFp, int vSync, int hTot, int vTot);
        expectFlags = {(h >= hVis + hFp) && (h < hVis + hFp + hSync),
                       (v >= vVis + vFp) && (v < vVis + vFp + vSync),
                       (h >= hVis), (v >= vVis),
                       (h == hTot - 1) && (v == vTot - 1)};
    endfunction

    task automatic advanceModel(input int hTot, input int vTot);
        mH++;
        if (mH == hTot) begin
            mH = 0;
            mV = (mV == vTot - 1) ? 0 : mV + 1;
        end
    endtask

    task automatic checkResetA(input string tag);
        checkOutput({tag, ".hcount"}, hcountA, 0);
        checkOutput({tag, ".vcount"}, vcountA, 0);
        checkOutput({tag, ".flags"}, {hsyncA, vsyncA, hblnkA, vblnkA, frame_endA}, 0);
    endtask

    task automatic scoreA(input string tag);
        checkOutput({tag, ".hcount"}, hcountA, mH);
        checkOutput({tag, ".vcount"}, vcountA, mV);
        checkOutput({tag, ".flags"}, {hsyncA, vsyncA, hblnkA, vblnkA, frame_endA},
                    expectFlags(mH, mV, 800, 40, 128, 600, 1, 4, AHT, AVT));
    endtask

    task automatic scoreB(input string tag);
        checkOutput({tag, ".hcount"}, hcountB, mH);
        checkOutput({tag, ".vcount"}, vcountB, mV);
        checkOutput({tag, ".flags"}, {hsyncB, vsyncB, hblnkB, vblnkB, frame_endB},
                    expectFlags(mH, mV, 16, 2, 4, 10, 1, 2, BHT, BVT));
    endtask

    task automatic applyStimulus();
        int prevH, prevV, lastZero, hsyncCycles, hblnkRises, hsyncRises, found;
        logic prevHblnk, prevHsync;
        int feCount, lastFe, vsyncCycles, vblnkCycles;
        logic prevVsync, prevFe;

        // Full-size instance: reset, release and two complete lines.
        rstA = 1'b0;
        rstB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk40);
            checkResetA("A.reset");
        end
        rstA = 1'b1;
        mH = 0; mV = 0;
        prevH = 0; prevV = 0; lastZero = 0;
        prevHblnk = 1'b0; prevHsync = 1'b0;
        hsyncCycles = 0; hblnkRises = 0; hsyncRises = 0;
        for (int cyc = 1; cyc <= 2 * AHT + 10; cyc++) begin
            @(posedge clk40);
            advanceModel(AHT, AVT);
            @(negedge clk40);
            scoreA("A.run");
            if (cyc == 1) checkOutput("A.firstCount", hcountA, 1);
            if (hblnkA && !prevHblnk) begin
                hblnkRises++;
                checkOutput("A.hblnkRiseAt", hcountA, 800);
            end
            if (hsyncA && !prevHsync) begin
                hsyncRises++;
                checkOutput("A.hsyncRiseAt", hcountA, 840);
            end
            if (!hsyncA && prevHsync) checkOutput("A.hsyncFallAt", hcountA, 968);
            if (hsyncA && vcountA == 0) hsyncCycles++;
            if (prevH == 1055) begin
                checkOutput("A.wrapH", hcountA, 0);
                checkOutput("A.wrapV", vcountA, prevV + 1);
            end
            if (hcountA == 0) begin
                checkOutput("A.linePeriod", cyc - lastZero, AHT);
                lastZero = cyc;
            end
            prevH = hcountA; prevV = vcountA;
            prevHblnk = hblnkA; prevHsync = hsyncA;
        end
        checkOutput("A.hsyncWidth", hsyncCycles, 128);
        checkOutput("A.hblnkRises", hblnkRises, 2);
        checkOutput("A.hsyncRises", hsyncRises, 2);

        // Asynchronous reset in the middle of a line, between clock edges.
        found = 0;
        for (int i = 0; i < 4000 && found == 0; i++) begin
            @(negedge clk40);
            if (hcountA == 500 && vcountA == 2) found = 1;
        end
        checkOutput("A.reachMid", found, 1);
        #5 rstA = 1'b0;
        #1 checkResetA("A.midReset");
        repeat (3) @(negedge clk40);
        rstA = 1'b1;
        mH = 0; mV = 0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk40);
            advanceModel(AHT, AVT);
            @(negedge clk40);
            scoreA("A.restart");
        end

        // Shrunken instance: three whole frames plus a few pixels.
        @(negedge clk40);
        checkOutput("B.reset.hcount", hcountB, 0);
        checkOutput("B.reset.flags", {hsyncB, vsyncB, hblnkB, vblnkB, frame_endB}, 0);
        rstB = 1'b1;
        mH = 0; mV = 0;
        feCount = 0; lastFe = -1; vsyncCycles = 0; vblnkCycles = 0;
        prevVsync = 1'b0; prevFe = 1'b0;
        for (int cyc = 1; cyc <= 3 * BHT * BVT + 5; cyc++) begin
            @(posedge clk40);
            advanceModel(BHT, BVT);
            @(negedge clk40);
            scoreB("B.run");
            if (frame_endB) begin
                checkOutput("B.frameEndH", hcountB, 24);
                checkOutput("B.frameEndV", vcountB, 14);
                if (lastFe >= 0) checkOutput("B.framePeriod", cyc - lastFe, BHT * BVT);
                lastFe = cyc;
                feCount++;
            end
            if (prevFe) begin
                checkOutput("B.afterFrameH", hcountB, 0);
                checkOutput("B.afterFrameV", vcountB, 0);
                checkOutput("B.afterFrameFlags", {hsyncB, vsyncB, hblnkB, vblnkB, frame_endB}, 0);
            end
            if (vsyncB != prevVsync) checkOutput("B.vsyncEdgeH", hcountB, 0);
            if (vsyncB) vsyncCycles++;
            if (vblnkB) vblnkCycles++;
            prevVsync = vsyncB; prevFe = frame_endB;
        end
        checkOutput("B.frameEndCount", feCount, 3);
        checkOutput("B.vsyncCycles", vsyncCycles, 3 * 2 * BHT);
        checkOutput("B.vblnkCycles", vblnkCycles, 3 * 5 * BHT);
    endtask

    initial begin
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
